// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressable data memory with a valid/ready
// request/response handshake. Big-endian lanes within each 32-bit word,
// programmable read wait states, error flagging for misaligned,
// out-of-range and illegal-size accesses, and a zeroing sweep after reset.
module data_memory_ctrl #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0]    WAIT_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH_WORDS - 1);
  localparam bit            NO_WAIT   = (WAIT_STATES == 0);

  // Storage and control state
  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [1:0]    r_state;
  logic [AW-1:0] r_clr_idx;
  logic [3:0]    r_wait_cnt;
  logic          r_err;

  // Latched request fields (data path, no reset needed)
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [1:0]    r_addr_lo;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_rdata;

  // Combinational helpers
  logic          w_accept;
  logic          w_req_err;
  logic [AW-1:0] w_req_idx;
  logic          w_enter_resp;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_idx;
  logic [31:0]   w_mem_mask;
  logic [31:0]   w_mem_data;
  logic [AW-1:0] w_ld_idx;
  logic [1:0]    w_ld_lo;
  logic [1:0]    w_ld_size;
  logic          w_ld_uns;
  logic          w_ld_kill;
  logic [31:0]   w_ld_data;

  // Any of: address beyond the array, misaligned half/word, or size 11.
  function automatic logic f_req_err(input logic [31:0] addr, input logic [1:0] size);
    logic oor;
    logic mis;
    logic ill;
    oor = |addr[31:AW+2];
    mis = ((size == SZ_HALF) && addr[0]) || ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    ill = (size == 2'b11);
    return oor | mis | ill;
  endfunction

  // Byte-enable mask for a store; lane 00 is the most significant byte.
  function automatic logic [31:0] f_lane_mask(input logic [1:0] size, input logic [1:0] lo);
    logic [31:0] m;
    m = 32'h0000_0000;
    case (size)
      SZ_BYTE: begin
        case (lo)
          2'b00:   m = 32'hFF00_0000;
          2'b01:   m = 32'h00FF_0000;
          2'b10:   m = 32'h0000_FF00;
          default: m = 32'h0000_00FF;
        endcase
      end
      SZ_HALF: m = lo[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
      SZ_WORD: m = 32'hFFFF_FFFF;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  // Store data replicated across all lanes so the mask alone picks the target.
  function automatic logic [31:0] f_lane_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  // Select the addressed byte/half from a word and sign- or zero-extend it.
  function automatic logic [31:0] f_load_ext(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] lo, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (lo)
      2'b00:   b = word[31:24];
      2'b01:   b = word[23:16];
      2'b10:   b = word[15:8];
      default: b = word[7:0];
    endcase
    h = lo[1] ? word[15:0] : word[31:16];
    case (size)
      SZ_BYTE: r = uns ? {24'h00_0000, b} : 32'(b);
      SZ_HALF: r = uns ? {16'h0000, h}    : 32'(h);
      default: r = word;
    endcase
    return r;
  endfunction

  assign w_accept  = (r_state == S_IDLE) && req_valid;
  assign w_req_err = f_req_err(req_addr, req_size);
  assign w_req_idx = req_addr[AW+1:2];

  // The response word is captured on the edge that moves into RESP.
  assign w_enter_resp = (w_accept && NO_WAIT) ||
                        ((r_state == S_WAIT) && (r_wait_cnt == 4'd0));

  // Memory write port: clear sweep, or the lanes of a legal store at accept.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_idx  = w_req_idx;
    w_mem_mask = 32'h0000_0000;
    w_mem_data = 32'h0000_0000;
    if (r_state == S_CLEAR) begin
      w_mem_we   = 1'b1;
      w_mem_idx  = r_clr_idx;
      w_mem_mask = 32'hFFFF_FFFF;
    end else if (w_accept && req_we && !w_req_err) begin
      w_mem_we   = 1'b1;
      w_mem_mask = f_lane_mask(req_size, req_addr[1:0]);
      w_mem_data = f_lane_data(req_size, req_wdata);
    end
  end

  // Load source: the live request when entering RESP straight from IDLE,
  // otherwise the fields latched at accept.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_ld_idx  = w_req_idx;
      w_ld_lo   = req_addr[1:0];
      w_ld_size = req_size;
      w_ld_uns  = req_unsigned;
      w_ld_kill = req_we | w_req_err;
    end else begin
      w_ld_idx  = r_idx;
      w_ld_lo   = r_addr_lo;
      w_ld_size = r_size;
      w_ld_uns  = r_uns;
      w_ld_kill = r_we | r_err;
    end
    w_ld_data = w_ld_kill ? 32'h0000_0000
                          : f_load_ext(r_mem[w_ld_idx], w_ld_size, w_ld_lo, w_ld_uns);
  end

  // Array write, merging the enabled lanes with the existing word.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= (r_mem[w_mem_idx] & ~w_mem_mask) | (w_mem_data & w_mem_mask);
    end
  end

  // Request fields and response data; qualified by state, so no reset required.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we      <= req_we;
      r_size    <= req_size;
      r_uns     <= req_unsigned;
      r_addr_lo <= req_addr[1:0];
      r_idx     <= w_req_idx;
    end
    if (w_enter_resp) begin
      r_rdata <= w_ld_data;
    end
  end

  // Control FSM: clear sweep, idle/accept, wait countdown, response hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_CLEAR;
      r_clr_idx  <= '0;
      r_wait_cnt <= 4'd0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_idx <= r_clr_idx + 1'b1;
          if (r_clr_idx == LAST_IDX) begin
            r_state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (w_accept) begin
            r_err <= w_req_err;
            if (NO_WAIT) begin
              r_state <= S_RESP;
            end else begin
              r_state    <= S_WAIT;
              r_wait_cnt <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end
        default: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = rsp_valid ? r_rdata : 32'h0000_0000;
  assign rsp_err   = rsp_valid & r_err;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: table-driven requests with a response scoreboard,
// plus hand-written sequences for reset sweep, stall and mid-wait reset.
module tb_data_memory_ctrl;

  localparam int DEPTH = 64;
  localparam int WS    = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event not seen within cycle bound", name);
  endtask

  task automatic add_vec(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rd; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after rsp_valid is seen.
  task automatic do_req(input vec_t v, input int id);
    int   k;
    exp_t e;
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    k = 0;
    do begin @(negedge clk); k++; end while (!req_ready && k < 50);
    if (!req_ready) fail_now($sformatf("accept[%0d]", id));
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.id = id;
    sb_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    k = 0;
    do begin @(negedge clk); k++; end while (!rsp_valid && k < 50);
    if (!rsp_valid) fail_now($sformatf("rsp_valid[%0d]", id));
    else chk($sformatf("latency[%0d]", id), 32'(k), 32'(1 + WS));
    @(posedge clk); #1;
  endtask

  // Called at posedge+1 just after reset release; counts cycles with req_ready low.
  task automatic wait_clear(input string name);
    int k;
    bit saw;
    k = 0; saw = 1'b0;
    while (k < 1000) begin
      @(negedge clk);
      if (req_ready) break;
      if (rsp_valid) saw = 1'b1;
      k++;
    end
    chk({name, "_cycles"}, 32'(k), 32'(DEPTH));
    chk({name, "_no_rsp"}, 32'(saw), 32'h0);
    @(posedge clk); #1;
  endtask

  // Scoreboard: compare every completed handshake; idle outputs must be zero.
  always @(negedge clk) begin
    if (reset) begin
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b with nothing expected",
                   rsp_rdata, rsp_err);
        end else begin
          mon_e = sb_q.pop_front();
          chk($sformatf("rsp_rdata[%0d]", mon_e.id), rsp_rdata, mon_e.rdata);
          chk($sformatf("rsp_err[%0d]", mon_e.id), 32'(rsp_err), 32'(mon_e.err));
        end
      end else if (!rsp_valid) begin
        chk("idle_rsp_zero", {rsp_rdata[31:1], rsp_rdata[0] | rsp_err}, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // we size uns addr wdata exp_rdata exp_err
    add_vec(0, 2'b10, 0, 32'h0000_0000, 32'h0,          32'h0000_0000, 0);
    add_vec(0, 2'b10, 0, 32'h0000_00FC, 32'h0,          32'h0000_0000, 0);
    add_vec(1, 2'b10, 0, 32'h0000_0014, 32'hDEAD_BEEF,  32'h0000_0000, 0);
    add_vec(0, 2'b10, 0, 32'h0000_0014, 32'h0,          32'hDEAD_BEEF, 0);
    add_vec(1, 2'b10, 0, 32'h0000_0008, 32'h1122_3344,  32'h0000_0000, 0);
    add_vec(1, 2'b00, 0, 32'h0000_000A, 32'hAAAA_AA7F,  32'h0000_0000, 0);
    add_vec(0, 2'b10, 0, 32'h0000_0008, 32'h0,          32'h1122_7F44, 0);
    add_vec(0, 2'b00, 0, 32'h0000_0008, 32'h0,          32'h0000_0011, 0);
    add_vec(1, 2'b00, 0, 32'h0000_000B, 32'h5555_5580,  32'h0000_0000, 0);
    add_vec(0, 2'b00, 0, 32'h0000_000B, 32'h0,          32'hFFFF_FF80, 0);
    add_vec(0, 2'b00, 1, 32'h0000_000B, 32'h0,          32'h0000_0080, 0);
    add_vec(0, 2'b00, 0, 32'h0000_0009, 32'h0,          32'h0000_0022, 0);
    add_vec(0, 2'b00, 1, 32'h0000_000A, 32'h0,          32'h0000_007F, 0);
    add_vec(0, 2'b01, 0, 32'h0000_0008, 32'h0,          32'h0000_1122, 0);
    add_vec(0, 2'b01, 0, 32'h0000_000A, 32'h0,          32'h0000_7F80, 0);
    add_vec(0, 2'b01, 0, 32'h0000_0014, 32'h0,          32'hFFFF_DEAD, 0);
    add_vec(0, 2'b01, 1, 32'h0000_0016, 32'h0,          32'h0000_BEEF, 0);
    add_vec(0, 2'b01, 0, 32'h0000_0016, 32'h0,          32'hFFFF_BEEF, 0);
    add_vec(1, 2'b01, 0, 32'h0000_0016, 32'h1234_5678,  32'h0000_0000, 0);
    add_vec(0, 2'b10, 1, 32'h0000_0014, 32'h0,          32'hDEAD_5678, 0);
    add_vec(1, 2'b10, 0, 32'h0000_00FC, 32'hCAFE_F00D,  32'h0000_0000, 0);
    add_vec(0, 2'b10, 0, 32'h0000_00FC, 32'h0,          32'hCAFE_F00D, 0);
    // error cases: misaligned, illegal size, out of range
    add_vec(0, 2'b01, 0, 32'h0000_0009, 32'h0,          32'h0000_0000, 1);
    add_vec(1, 2'b10, 0, 32'h0000_0006, 32'hFFFF_FFFF,  32'h0000_0000, 1);
    add_vec(1, 2'b11, 0, 32'h0000_0008, 32'h0000_0000,  32'h0000_0000, 1);
    add_vec(0, 2'b11, 1, 32'h0000_0008, 32'h0,          32'h0000_0000, 1);
    add_vec(0, 2'b10, 0, 32'h0000_0100, 32'h0,          32'h0000_0000, 1);
    add_vec(0, 2'b10, 0, 32'h0000_0108, 32'h0,          32'h0000_0000, 1);
    add_vec(1, 2'b10, 0, 32'h0000_0100, 32'hFFFF_FFFF,  32'h0000_0000, 1);
    add_vec(1, 2'b00, 0, 32'h8000_0014, 32'h0000_00FF,  32'h0000_0000, 1);
    // memory unchanged by the rejected stores
    add_vec(0, 2'b10, 0, 32'h0000_0004, 32'h0,          32'h0000_0000, 0);
    add_vec(0, 2'b10, 0, 32'h0000_0014, 32'h0,          32'hDEAD_5678, 0);
    add_vec(0, 2'b10, 0, 32'h0000_0008, 32'h0,          32'h1122_7F80, 0);
    add_vec(0, 2'b10, 0, 32'h0000_0000, 32'h0,          32'h0000_0000, 0);

    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err",   32'(rsp_err), 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    wait_clear("clear1");

    for (int i = 0; i < vecs.size(); i++) begin
      do_req(vecs[i], i);
    end

    // Response stall: held stable with req_ready low, then IDLE right after release.
    begin
      vec_t v;
      v.we = 0; v.size = 2'b10; v.uns = 0; v.addr = 32'h14; v.wdata = 32'h0;
      v.exp_rdata = 32'hDEAD_5678; v.exp_err = 0;
      rsp_ready = 1'b0;
      do_req(v, 100);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("stall_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("stall_rsp_rdata", rsp_rdata, 32'hDEAD_5678);
        chk("stall_req_ready", 32'(req_ready), 32'h0);
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("release_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("release_req_ready", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
    end

    // Reset while in WAIT: outputs drop at once, sweep reruns, no response.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h14;
    @(negedge clk);
    chk("mid_rst_accept", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'h0;
    reset = 1'b0;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("mid_rst_rsp_err",   32'(rsp_err), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    wait_clear("clear2");
    begin
      vec_t v;
      v.we = 0; v.size = 2'b10; v.uns = 0; v.addr = 32'h14; v.wdata = 32'h0;
      v.exp_rdata = 32'h0; v.exp_err = 0;
      do_req(v, 200);
      v.addr = 32'hFC;
      do_req(v, 201);
    end

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
